// File: rtl/alu_seq_ctrl.sv
// Sequencer driving the ALU mux op select and operands, and handing captured results to the
// 7-segment display over a valid/ready handshake. Supports single-op and scan-all-ops modes.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned RES_WIDTH     = 16,
    parameter int unsigned OP_BITS       = 3,
    parameter int unsigned NUM_OPS       = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 100_000_000,
    parameter int unsigned HOLD_W        = 27
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 scan_mode_i,
    input  logic [OP_BITS-1:0]   op_manual_i,
    input  logic [WIDTH-1:0]     operand_a_i,
    input  logic [WIDTH-1:0]     operand_b_i,
    output logic [WIDTH-1:0]     num_1_o,
    output logic [WIDTH-1:0]     num_2_o,
    output logic [OP_BITS-1:0]   op_select_o,
    input  logic [RES_WIDTH-1:0] alu_result_i,
    output logic [RES_WIDTH-1:0] disp_data_o,
    output logic                 disp_valid_o,
    input  logic                 disp_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {StIdle, StSettle, StSend, StHold} state_e;

    localparam logic [HOLD_W-1:0]  SettleInit = HOLD_W'(SETTLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HoldInit   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [OP_BITS-1:0] LastOp     = OP_BITS'(NUM_OPS - 1);

    state_e                 state_q;
    logic [HOLD_W-1:0]      cnt_q;
    logic                   scan_q;
    logic                   stop_pend_q;
    logic [WIDTH-1:0]       num_1_q;
    logic [WIDTH-1:0]       num_2_q;
    logic [OP_BITS-1:0]     op_q;
    logic [RES_WIDTH-1:0]   disp_data_q;
    logic                   disp_valid_q;
    logic                   busy_q;
    logic                   done_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            scan_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            num_1_q      <= '0;
            num_2_q      <= '0;
            op_q         <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    stop_pend_q <= 1'b0;
                    if (start_i && !stop_i) begin
                        num_1_q <= operand_a_i;
                        num_2_q <= operand_b_i;
                        op_q    <= scan_mode_i ? '0 : op_manual_i;
                        scan_q  <= scan_mode_i;
                        cnt_q   <= SettleInit;
                        busy_q  <= 1'b1;
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (stop_i) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        disp_data_q  <= alu_result_i;
                        disp_valid_q <= 1'b1;
                        state_q      <= StSend;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StSend: begin
                    // A stop here must not abort an offered result; it is honoured after transfer.
                    if (stop_i) stop_pend_q <= 1'b1;
                    if (disp_valid_q && disp_ready_i) begin
                        disp_valid_q <= 1'b0;
                        if (!scan_q || stop_pend_q || stop_i) begin
                            stop_pend_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            cnt_q   <= HoldInit;
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (stop_i) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        op_q    <= (op_q == LastOp) ? '0 : op_q + 1'b1;
                        // Re-sample so live counter changes show up on the next op.
                        num_1_q <= operand_a_i;
                        num_2_q <= operand_b_i;
                        cnt_q   <= SettleInit;
                        state_q <= StSettle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign num_1_o      = num_1_q;
    assign num_2_o      = num_2_q;
    assign op_select_o  = op_q;
    assign disp_data_o  = disp_data_q;
    assign disp_valid_o = disp_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: single op, backpressure, scan with wrap and operand change,
// stop handling and asynchronous reset, against a bench-owned ALU model.
module tb_alu_seq_ctrl;

    logic        clk_i;
    logic        reset_i;
    logic        start_i;
    logic        stop_i;
    logic        scan_mode_i;
    logic [2:0]  op_manual_i;
    logic [7:0]  operand_a_i;
    logic [7:0]  operand_b_i;
    logic [7:0]  num_1_o;
    logic [7:0]  num_2_o;
    logic [2:0]  op_select_o;
    logic [15:0] alu_result_i;
    logic [15:0] disp_data_o;
    logic        disp_valid_o;
    logic        disp_ready_i;
    logic        busy_o;
    logic        done_o;

    int n_vec;
    int n_err;
    int xfer_cnt;
    int done_cnt;
    int cyc;

    alu_seq_ctrl #(
        .WIDTH        (8),
        .RES_WIDTH    (16),
        .OP_BITS      (3),
        .NUM_OPS      (8),
        .SETTLE_CYCLES(2),
        .HOLD_CYCLES  (4),
        .HOLD_W       (27)
    ) u_dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .scan_mode_i (scan_mode_i),
        .op_manual_i (op_manual_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .num_1_o     (num_1_o),
        .num_2_o     (num_2_o),
        .op_select_o (op_select_o),
        .alu_result_i(alu_result_i),
        .disp_data_o (disp_data_o),
        .disp_valid_o(disp_valid_o),
        .disp_ready_i(disp_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
        case (op)
            3'd0:    return {8'd0, a & b};
            3'd1:    return {8'd0, a | b};
            3'd2:    return {8'd0, a} + {8'd0, b};
            3'd3:    return {8'd0, a} - {8'd0, b};
            3'd4:    return {8'd0, a} * {8'd0, b};
            3'd5:    return {8'd0, a ^ b};
            3'd6:    return {a, b};
            default: return {8'd0, ~a};
        endcase
    endfunction

    assign alu_result_i = alu_model(num_1_o, num_2_o, op_select_o);

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (disp_valid_o && disp_ready_i) xfer_cnt <= xfer_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60 && !disp_valid_o; i++) tick();
        check("valid_wait", {31'd0, disp_valid_o}, 32'd1);
    endtask

    task automatic start_op(input logic scan, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b);
        scan_mode_i = scan;
        op_manual_i = op;
        operand_a_i = a;
        operand_b_i = b;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    initial begin
        int x0, d0, t_prev;
        logic [7:0] a_exp;
        n_vec = 0; n_err = 0; xfer_cnt = 0; done_cnt = 0; cyc = 0;
        reset_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; scan_mode_i = 1'b0;
        op_manual_i = '0; operand_a_i = '0; operand_b_i = '0; disp_ready_i = 1'b0;
        repeat (2) tick();
        check("rst_valid", {31'd0, disp_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_data", {16'd0, disp_data_o}, 32'd0);
        reset_i = 1'b0;
        tick();

        // Single mode, op 2 (add), 5 + 3.
        disp_ready_i = 1'b1;
        x0 = xfer_cnt;
        start_op(1'b0, 3'd2, 8'd5, 8'd3);
        check("s_busy", {31'd0, busy_o}, 32'd1);
        check("s_num1", {24'd0, num_1_o}, 32'd5);
        check("s_num2", {24'd0, num_2_o}, 32'd3);
        check("s_op", {29'd0, op_select_o}, 32'd2);
        check("s_valid_e0", {31'd0, disp_valid_o}, 32'd0);
        tick();
        check("s_valid_e1", {31'd0, disp_valid_o}, 32'd0);
        tick();
        check("s_valid_e2", {31'd0, disp_valid_o}, 32'd1);
        check("s_data", {16'd0, disp_data_o}, 32'd8);
        tick();
        check("s_valid_drop", {31'd0, disp_valid_o}, 32'd0);
        check("s_done", {31'd0, done_o}, 32'd1);
        check("s_idle", {31'd0, busy_o}, 32'd0);
        check("s_xfers", xfer_cnt - x0, 32'd1);
        tick();
        check("s_done_pulse", {31'd0, done_o}, 32'd0);

        // Backpressure: op 3 (sub), 9 - 4, ready low for 10 cycles.
        disp_ready_i = 1'b0;
        x0 = xfer_cnt;
        start_op(1'b0, 3'd3, 8'd9, 8'd4);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, disp_valid_o}, 32'd1);
            check("bp_data", {16'd0, disp_data_o}, 32'd5);
        end
        disp_ready_i = 1'b1;
        tick();
        check("bp_valid_drop", {31'd0, disp_valid_o}, 32'd0);
        check("bp_done", {31'd0, done_o}, 32'd1);
        check("bp_xfers", xfer_cnt - x0, 32'd1);
        tick();

        // Scan mode: 9 transfers (ops 0..7 then wrap to 0), A changes during HOLD of op 1.
        d0 = done_cnt;
        t_prev = 0;
        start_op(1'b1, 3'd5, 8'd5, 8'd3);
        for (int k = 0; k < 9; k++) begin
            a_exp = (k <= 1) ? 8'd5 : 8'd9;
            wait_valid();
            check("sc_op", {29'd0, op_select_o}, k % 8);
            check("sc_num1", {24'd0, num_1_o}, {24'd0, a_exp});
            check("sc_data", {16'd0, disp_data_o},
                  {16'd0, alu_model(a_exp, 8'd3, 3'(k % 8))});
            if (k > 0) check("sc_spacing", cyc - t_prev, 32'd7);
            t_prev = cyc;
            tick();
            if (k == 1) operand_a_i = 8'd9;
        end
        check("sc_no_done", done_cnt - d0, 32'd0);
        check("sc_busy", {31'd0, busy_o}, 32'd1);

        // Stop while in HOLD.
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("sh_done", {31'd0, done_o}, 32'd1);
        check("sh_busy", {31'd0, busy_o}, 32'd0);
        check("sh_valid", {31'd0, disp_valid_o}, 32'd0);
        x0 = xfer_cnt;
        repeat (15) tick();
        check("sh_no_xfer", xfer_cnt - x0, 32'd0);

        // Stop while in SEND with ready low: handshake still completes.
        disp_ready_i = 1'b0;
        start_op(1'b1, 3'd0, 8'd6, 8'd2);
        wait_valid();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        repeat (3) tick();
        check("ss_valid_held", {31'd0, disp_valid_o}, 32'd1);
        check("ss_busy", {31'd0, busy_o}, 32'd1);
        check("ss_data", {16'd0, disp_data_o}, 32'd2);
        x0 = xfer_cnt;
        disp_ready_i = 1'b1;
        tick();
        check("ss_xfers", xfer_cnt - x0, 32'd1);
        check("ss_done", {31'd0, done_o}, 32'd1);
        check("ss_idle", {31'd0, busy_o}, 32'd0);
        tick();

        // start together with stop in IDLE is ignored.
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("ab_busy", {31'd0, busy_o}, 32'd0);
        tick();
        check("ab_busy2", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset while a result is offered.
        disp_ready_i = 1'b0;
        d0 = done_cnt;
        start_op(1'b0, 3'd4, 8'd7, 8'd6);
        wait_valid();
        #2;
        reset_i = 1'b1;
        #1;
        check("ar_valid", {31'd0, disp_valid_o}, 32'd0);
        check("ar_busy", {31'd0, busy_o}, 32'd0);
        check("ar_num1", {24'd0, num_1_o}, 32'd0);
        check("ar_num2", {24'd0, num_2_o}, 32'd0);
        check("ar_op", {29'd0, op_select_o}, 32'd0);
        check("ar_data", {16'd0, disp_data_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        check("ar_no_done", done_cnt - d0, 32'd0);
        check("ar_idle", {31'd0, busy_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
